// File: rtl/if_stage_prefetch.sv
// Instruction-fetch prefetch stage: issues sequential fetches into a small queue
// and flushes it on branch/jump redirects.
module if_stage_prefetch #(
    parameter int                  WORD_LEN = 32,
    parameter int                  DEPTH    = 4,
    parameter logic [WORD_LEN-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         freeze,
    input  logic                         branch_taken,
    input  logic [WORD_LEN-1:0]          br_pc,
    input  logic [WORD_LEN-1:0]          branch_offset,
    input  logic                         jump_en,
    input  logic [WORD_LEN-1:0]          jump_target,
    output logic                         imem_req,
    output logic [WORD_LEN-1:0]          imem_addr,
    input  logic                         imem_valid,
    input  logic [WORD_LEN-1:0]          imem_rdata,
    output logic                         inst_valid,
    input  logic                         inst_ready,
    output logic [WORD_LEN-1:0]          inst_data,
    output logic [WORD_LEN-1:0]          inst_pc,
    output logic [$clog2(DEPTH+1)-1:0]   fill_level,
    output logic [1:0]                   state_dbg
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        S_RESET_WAIT = 2'd0,
        S_RUN        = 2'd1,
        S_REDIRECT   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_LEN-1:0] fetch_pc_q;
    logic                inflight_q;
    logic [WORD_LEN-1:0] inflight_addr_q;
    logic [CNT_W-1:0]    count_q;
    logic [PTR_W-1:0]    wptr_q, rptr_q;
    logic [WORD_LEN-1:0] q_pc   [DEPTH];
    logic [WORD_LEN-1:0] q_data [DEPTH];

    logic                redirect;
    logic [WORD_LEN-1:0] redirect_pc;
    logic [CNT_W:0]      occupancy;
    logic                room;
    logic                push, pop;

    // Branch wins over jump; shifting the full-width offset keeps its sign in the truncated sum.
    assign redirect    = branch_taken | jump_en;
    assign redirect_pc = branch_taken ? (br_pc + (branch_offset << 2)) : jump_target;

    // A response is only enqueued if its request is still tracked as in flight;
    // reset and redirect forget the in-flight request, which makes its response stale.
    assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign room      = occupancy < (CNT_W+1)'(DEPTH);
    assign push      = imem_valid & inflight_q & ~redirect;
    // Decode handshake: the head transfers on a cycle where inst_valid and inst_ready are both high.
    assign pop       = (count_q != '0) & inst_ready & ~redirect;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_RESET_WAIT;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RESET_WAIT: state_d = redirect ? S_REDIRECT : S_RUN;
            S_RUN:        state_d = redirect ? S_REDIRECT : S_RUN;
            S_REDIRECT:   state_d = redirect ? S_REDIRECT : S_RUN;
            default:      state_d = S_RESET_WAIT;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        state_dbg = state_q;
        if (state_q == S_RUN && !freeze && !redirect && room) imem_req = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q      <= RESET_PC;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            count_q         <= '0;
            wptr_q          <= '0;
            rptr_q          <= '0;
        end else if (redirect) begin
            fetch_pc_q <= redirect_pc;
            inflight_q <= 1'b0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            inflight_q <= imem_req;
            if (imem_req) begin
                inflight_addr_q <= fetch_pc_q;
                fetch_pc_q      <= fetch_pc_q + WORD_LEN'(4);
            end
            if (push) wptr_q <= wptr_q + PTR_W'(1);
            if (pop)  rptr_q <= rptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            q_pc[wptr_q]   <= inflight_addr_q;
            q_data[wptr_q] <= imem_rdata;
        end
    end

    assign imem_addr  = fetch_pc_q;
    assign inst_valid = (count_q != '0);
    assign inst_pc    = inst_valid ? q_pc[rptr_q]   : '0;
    assign inst_data  = inst_valid ? q_data[rptr_q] : '0;
    assign fill_level = count_q;

endmodule

// File: tb/tb_if_stage_prefetch.sv
// Bench for if_stage_prefetch: a queue-based reference model checked every cycle,
// plus directed scenarios pinned with hand-computed literals.
module tb_if_stage_prefetch;
    localparam int W = 32;
    localparam int DEPTH = 4;
    localparam logic [W-1:0] RST_PC = 32'h100;

    logic         clk, rst, freeze, branch_taken, jump_en;
    logic [W-1:0] br_pc, branch_offset, jump_target;
    logic         imem_req, imem_valid, inst_valid, inst_ready;
    logic [W-1:0] imem_addr, imem_rdata, inst_data, inst_pc;
    logic [2:0]   fill_level;
    logic [1:0]   state_dbg;

    if_stage_prefetch #(.WORD_LEN(W), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .br_pc(br_pc), .branch_offset(branch_offset), .jump_en(jump_en),
        .jump_target(jump_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
        .fill_level(fill_level), .state_dbg(state_dbg)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc_n = 0;

    typedef struct packed { logic [W-1:0] pc; logic [W-1:0] data; } ent_t;
    ent_t         m_q[$];
    logic [W-1:0] m_fetch_pc, m_inflight_addr;
    logic         m_inflight, m_exp_req;
    int           m_hold;

    logic [W-1:0] req_addr_q[$];
    int           req_cyc_q[$];
    logic [W-1:0] pop_q[$];

    function automatic logic [W-1:0] mem_func(input logic [W-1:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_A5A5;
    endfunction

    function automatic logic [W-1:0] req_at(input int i);
        return (i < req_addr_q.size()) ? req_addr_q[i] : 'x;
    endfunction

    function automatic int cyc_at(input int i);
        return (i < req_cyc_q.size()) ? req_cyc_q[i] : -1000;
    endfunction

    function automatic logic [W-1:0] pop_at(input int i);
        return (i < pop_q.size()) ? pop_q[i] : 'x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fetch_pc      = RST_PC;
        m_inflight      = 1'b0;
        m_inflight_addr = '0;
        m_hold          = 1;
    endtask

    // scoreboard: compare outputs with what the model says this cycle must show
    task automatic model_check();
        int   occ;
        ent_t h;
        occ = m_q.size() + (m_inflight ? 1 : 0);
        m_exp_req = (m_hold == 0) && !freeze && !(branch_taken || jump_en) && (occ < DEPTH);
        h = (m_q.size() > 0) ? m_q[0] : '0;
        chk("imem_req", imem_req, m_exp_req);
        if (m_exp_req) chk("imem_addr", imem_addr, m_fetch_pc);
        chk("inst_valid", inst_valid, m_q.size() > 0);
        chk("inst_pc", inst_pc, h.pc);
        chk("inst_data", inst_data, h.data);
        chk("fill_level", fill_level, m_q.size());
    endtask

    task automatic model_step();
        logic [W-1:0] tgt;
        ent_t         e;
        tgt = branch_taken ? (br_pc + branch_offset * W'(4)) : jump_target;
        if (!rst) begin
            model_reset();
        end else if (branch_taken || jump_en) begin
            m_q.delete();
            m_fetch_pc = tgt;
            m_inflight = 1'b0;
            m_hold     = 1;
        end else begin
            if (m_q.size() > 0 && inst_ready) void'(m_q.pop_front());
            if (m_inflight) begin
                e.pc   = m_inflight_addr;
                e.data = mem_func(m_inflight_addr);
                m_q.push_back(e);
            end
            m_hold     = 0;
            m_inflight = m_exp_req;
            if (m_exp_req) begin
                m_inflight_addr = m_fetch_pc;
                m_fetch_pc      = m_fetch_pc + 32'd4;
            end
        end
    endtask

    // one cycle: check, log, advance model, then drive the memory response after the edge
    task automatic tick();
        logic         nv;
        logic [W-1:0] nd;
        #1;
        model_check();
        if (imem_req) begin
            req_addr_q.push_back(imem_addr);
            req_cyc_q.push_back(cyc_n);
        end
        if (inst_valid && inst_ready && rst) pop_q.push_back(inst_pc);
        nv = imem_req;
        nd = mem_func(imem_addr);
        model_step();
        @(negedge clk);
        imem_valid = nv;
        imem_rdata = nv ? nd : '0;
        cyc_n++;
    endtask

    initial begin
        int n0, n1, p0, rel, tb, first_cyc, hits;
        logic [W-1:0] first_pc;

        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; jump_en = 1'b0;
        br_pc = '0; branch_offset = '0; jump_target = '0;
        imem_valid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        tick();
        chk("reset_state", state_dbg, 2'd0);

        // startup from RESET_PC with decode always ready
        rst = 1'b1; inst_ready = 1'b1;
        rel = cyc_n; n0 = req_addr_q.size(); p0 = pop_q.size();
        repeat (12) tick();
        chk("t1_first_req_cycle", cyc_at(n0) - rel + 1, 2);
        for (int i = 0; i < 4; i++) begin
            chk("t1_req_addr", req_at(n0 + i), 32'h100 + 32'(4 * i));
            chk("t1_pop_pc", pop_at(p0 + i), 32'h100 + 32'(4 * i));
        end

        // back-pressure from a fresh reset
        rst = 1'b0; tick(); rst = 1'b1;
        inst_ready = 1'b0; n0 = req_addr_q.size();
        repeat (12) tick();
        chk("t2_req_count", req_addr_q.size() - n0, 4);
        chk("t2_fill_full", fill_level, 4);
        chk("t2_req_idle", imem_req, 0);
        inst_ready = 1'b1; n1 = req_addr_q.size();
        tick();
        inst_ready = 1'b0;
        repeat (6) tick();
        chk("t2_refill_reqs", req_addr_q.size() - n1, 1);

        // branch with three queued entries and a response arriving on the redirect cycle
        inst_ready = 1'b1; tick();
        inst_ready = 1'b0; tick();
        chk("t3_fill_before", fill_level, 3);
        branch_taken = 1'b1; br_pc = 32'h200; branch_offset = 32'hFFFF_FFFE;
        tb = cyc_n; n0 = req_addr_q.size();
        tick();
        branch_taken = 1'b0;
        chk("t3_fill_cleared", fill_level, 0);
        first_cyc = -1; first_pc = '0;
        for (int k = 0; k < 8; k++) begin
            if (inst_valid && first_cyc < 0) begin
                first_cyc = cyc_n;
                first_pc  = inst_pc;
            end
            tick();
        end
        chk("t3_valid_latency", first_cyc - tb, 4);
        chk("t3_first_pc", first_pc, 32'h1F8);
        chk("t3_first_req_addr", req_at(n0), 32'h1F8);
        chk("t3_first_req_cycle", cyc_at(n0) - tb, 2);

        // branch beats jump in the same cycle
        inst_ready = 1'b1; branch_taken = 1'b1; jump_en = 1'b1;
        jump_target = 32'h400; br_pc = 32'h300; branch_offset = 32'd4;
        n0 = req_addr_q.size();
        tick();
        branch_taken = 1'b0; jump_en = 1'b0;
        repeat (10) tick();
        chk("t4_branch_target", req_at(n0), 32'h310);
        hits = 0;
        for (int i = n0; i < req_addr_q.size(); i++) if (req_addr_q[i] == 32'h400) hits++;
        chk("t4_jump_never_fetched", hits, 0);

        // address wrap, then a five-cycle freeze with a request outstanding
        jump_en = 1'b1; jump_target = 32'hFFFF_FFF8; n0 = req_addr_q.size();
        tick();
        jump_en = 1'b0;
        repeat (4) tick();
        chk("t5_pre_wrap_addr", req_at(n0 + 1), 32'hFFFF_FFFC);
        chk("t5_wrap_addr", req_at(n0 + 2), 32'h0);
        freeze = 1'b1; n1 = req_addr_q.size(); p0 = pop_q.size();
        repeat (5) tick();
        chk("t5_freeze_reqs", req_addr_q.size() - n1, 0);
        chk("t5_freeze_pops", pop_q.size() - p0, 2);
        chk("t5_outstanding_enqueued", pop_at(p0 + 1), 32'h0);
        freeze = 1'b0;
        tick();
        chk("t5_resume_addr", req_at(n1), 32'h4);

        // reset with a nearly full queue and a request in flight
        inst_ready = 1'b0;
        repeat (10) tick();
        chk("t6_fill_full", fill_level, 4);
        inst_ready = 1'b1; tick();
        inst_ready = 1'b0; rst = 1'b0;
        #1;
        chk("t6_req_in_flight", imem_req, 1);
        tick();
        rst = 1'b1;
        chk("t6_state", state_dbg, 2'd0);
        chk("t6_fill", fill_level, 0);
        chk("t6_inst_pc", inst_pc, 0);
        inst_ready = 1'b1; p0 = pop_q.size();
        repeat (8) tick();
        chk("t6_first_pop_after_reset", pop_at(p0), 32'h100);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
